// File: rtl/alu_seq_ctrl.sv
// Sequencer that time-multiplexes one external W-bit adder for ADD, SUB and unsigned shift-and-add MUL.
// Latency: accept->result valid in 2 cycles (ADD/SUB), W+1 cycles (MUL), 1 cycle (reserved op).
// Backpressure: accepts only in IDLE; the result is held in DONE until res_ready, and no new request is taken before then.
module alu_seq_ctrl #(
   parameter int W  = 16,
   parameter int CW = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [1:0]   req_op,
   input  logic [W-1:0] req_a,
   input  logic [W-1:0] req_b,
   output logic [W-1:0] add_a,
   output logic [W-1:0] add_b,
   output logic         add_cin,
   input  logic [W-1:0] add_sum,
   input  logic         add_cout,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W-1:0] res_lo,
   output logic [W-1:0] res_hi,
   output logic         res_cout,
   output logic         res_ovf,
   output logic         res_err,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, EXEC, MUL_IT, DONE} state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;

   state_t          state;
   logic [1:0]      op;
   logic [W-1:0]    a;      // operand A; doubles as the multiplicand during MUL
   logic [W-1:0]    b;      // operand B; doubles as the multiplier/quotient shift register (mq) during MUL
   logic [W-1:0]    acc;
   logic [CW-1:0]   cnt;
   logic            ovf_now;

   // Handshake and status flags decode straight from the state register.
   assign req_ready = (state == IDLE);
   assign res_valid = (state == DONE);
   assign busy      = (state != IDLE);

   // Signed overflow: operands of equal sign producing a sum of the other sign.
   assign ovf_now = (a[W-1] == add_b[W-1]) && (add_sum[W-1] != a[W-1]);

   // Adder operand steering; the adder sees zeros whenever it is not in use.
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      case (state)
         EXEC: begin
            add_a = a;
            if (op == OP_SUB) begin
               add_b   = ~b;
               add_cin = 1'b1;
            end else begin
               add_b = b;
            end
         end
         MUL_IT: begin
            add_a = acc;
            add_b = b[0] ? a : '0;
         end
         default: ;
      endcase
   end

   // Control FSM, operand capture, multiply datapath and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         op       <= '0;
         a        <= '0;
         b        <= '0;
         acc      <= '0;
         cnt      <= '0;
         res_lo   <= '0;
         res_hi   <= '0;
         res_cout <= 1'b0;
         res_ovf  <= 1'b0;
         res_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op  <= req_op;
                  a   <= req_a;
                  b   <= req_b;
                  acc <= '0;
                  cnt <= '0;
                  case (req_op)
                     OP_ADD, OP_SUB: state <= EXEC;
                     OP_MUL:         state <= MUL_IT;
                     default: begin
                        res_lo   <= '0;
                        res_hi   <= '0;
                        res_cout <= 1'b0;
                        res_ovf  <= 1'b0;
                        res_err  <= 1'b1;
                        state    <= DONE;
                     end
                  endcase
               end
            end
            EXEC: begin
               res_lo   <= add_sum;
               res_hi   <= '0;
               res_cout <= add_cout;
               res_ovf  <= ovf_now;
               res_err  <= 1'b0;
               state    <= DONE;
            end
            MUL_IT: begin
               // {acc, mq} shifts right one place per pass with the adder carry entering at the top.
               acc <= {add_cout, add_sum[W-1:1]};
               b   <= {add_sum[0], b[W-1:1]};
               cnt <= cnt + 1'b1;
               if (cnt == CW'(W-1)) begin
                  res_hi   <= {add_cout, add_sum[W-1:1]};
                  res_lo   <= {add_sum[0], b[W-1:1]};
                  res_cout <= 1'b0;
                  res_ovf  <= 1'b0;
                  res_err  <= 1'b0;
                  state    <= DONE;
               end
            end
            DONE: begin
               if (res_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Multi-cycle operation sequencer that owns one external W-bit carry-lookahead adder built from the team's CLA slices, and time-multiplexes it to execute ADD, SUB and unsigned MUL. MUL uses shift-and-add. Requests arrive on a valid/ready handshake; results leave on a valid/ready handshake. The adder itself is purely combinational and outside this block; this block only drives its operands and samples its sum/carry.

Parameters:
W, 16, operand width and width of the external adder (W >= 4, multiple of 4)
CW, 5, iteration counter width; must satisfy 2^CW > W

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_op  in  2  00 ADD, 01 SUB, 10 MUL, 11 reserved
req_a  in  W  operand A (multiplicand for MUL)
req_b  in  W  operand B (multiplier for MUL)
add_a  out  W  adder operand A
add_b  out  W  adder operand B
add_cin  out  1  adder carry-in
add_sum  in  W  adder sum, combinational from add_a/add_b/add_cin
add_cout  in  1  adder carry-out
res_valid  out  1  result present
res_ready  in  1  consumer accepts result
res_lo  out  W  ADD/SUB result; MUL low word
res_hi  out  W  MUL high word; 0 for ADD/SUB
res_cout  out  1  adder carry-out (SUB: 1 = no borrow); 0 for MUL
res_ovf  out  1  signed overflow for ADD/SUB; 0 for MUL
res_err  out  1  reserved opcode flagged
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all registers cleared. res_* = 0, busy = 0, add_a/add_b/add_cin = 0, and req_ready = 1 once reset is released. Reset mid-operation aborts the operation with no result produced.
- States: IDLE, EXEC, MUL_IT, DONE.
- IDLE: req_ready = 1. Acceptance occurs when req_valid && req_ready at a rising edge in cycle N. That edge captures op, a and b into internal registers. Operand inputs are ignored at all other times.
  - ADD or SUB: go to EXEC.
  - MUL: acc = 0, mq = b, mcand = a, cnt = 0, go to MUL_IT.
  - op 11: go to DONE with res_err = 1 and all other res_* = 0. res_valid is high in cycle N+1.
- EXEC (one cycle):
  - ADD drives add_a = a, add_b = b, add_cin = 0.
  - SUB drives add_a = a, add_b = ~b, add_cin = 1.
  - At the edge, latch res_lo = add_sum, res_cout = add_cout, res_hi = 0, and res_ovf = (a[W-1] == add_b[W-1]) && (add_sum[W-1] != a[W-1]). Go to DONE; res_valid is high in cycle N+2.
- MUL_IT (W cycles, cnt 0..W-1): drive add_a = acc, add_b = mq[0] ? mcand : 0, add_cin = 0. Each edge updates:
  - acc <= {add_cout, add_sum[W-1:1]}
  - mq <= {add_sum[0], mq[W-1:1]}
  - cnt <= cnt + 1
  - After the edge with cnt == W-1, latch res_hi = new acc, res_lo = new mq, res_cout = 0, res_ovf = 0, and go to DONE. res_valid is high in cycle N+W+1.
- Adder drive in IDLE and DONE: add_a = 0, add_b = 0, add_cin = 0.
- DONE: res_valid = 1 and req_ready = 0. All res_* hold stable until res_valid && res_ready at an edge, which moves the block to IDLE with res_valid = 0 next cycle. res_err and res_* values remain in their registers until the next result is latched. Because requests are accepted only in IDLE, minimum spacing between accepts is 3 cycles for ADD/SUB and W+2 cycles for MUL.
- req_valid high outside IDLE has no effect; the request is not consumed.
- busy = (state != IDLE).
- Arithmetic is modulo 2^W for each adder pass. MUL is an unsigned W×W to 2W product.

Test Plan:
- ADD req_a=0xFFFF, req_b=0x0001, accepted cycle N -> res_valid in N+2; res_lo=0x0000, res_cout=1, res_ovf=0, res_hi=0.
- SUB 0x0005-0x0007 -> res_lo=0xFFFE, res_cout=0. SUB 0x8000-0x0001 -> res_lo=0x7FFF, res_ovf=1, res_cout=1.
- MUL 0xFFFF*0xFFFF accepted cycle N -> busy for cycles N+1..N+17; res_valid in N+17; res_hi=0xFFFE, res_lo=0x0001. MUL 0x1234*0x0000 -> both words 0.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid while req_valid=1 with a new request. Required: res_* stable, req_ready=0, new request not accepted until the cycle after the res_ready handshake.
- req_op=11 accepted cycle N -> res_valid in N+1, res_err=1, res_lo=res_hi=0; add_* remain 0 throughout.
- Pull rst_n low during MUL iteration 8 -> res_valid, busy and add_* go to 0 immediately, with no result produced. After release, ADD 0x0003+0x0004 -> res_lo=0x0007.
